// File: rtl/opendap_sw_dp_regs.sv
// SW-DP register file and AP access sequencer: DP register decode, sticky error
// flags, power-up handshakes and a single-outstanding AP request with posted reads.
module opendap_sw_dp_regs #(
  parameter logic [31:0] DPIDR     = 32'h2ba01477,
  parameter logic [31:0] TARGETID  = 32'h00000001,
  parameter logic [3:0]  TINSTANCE = 4'h0
) (
  input  logic        swclk,
  input  logic        rst_n,
  input  logic [1:0]  bus_addr,
  input  logic        bus_r_nw,
  input  logic        bus_ap_ndp,
  input  logic [31:0] bus_wdata,
  input  logic        bus_en,
  output logic [31:0] bus_rdata,
  input  logic        dp_set_wdataerr,
  input  logic        dp_set_stickyorun,
  output logic        dp_orundetect,
  output logic        dp_acc_fault,
  output logic        dp_acc_protocol_err,
  output logic        ap_rdy,
  output logic        ap_en,
  output logic        ap_write,
  output logic [7:0]  ap_sel,
  output logic [7:0]  ap_addr,
  output logic [31:0] ap_wdata,
  input  logic [31:0] ap_rdata,
  input  logic        ap_ready,
  input  logic        ap_err,
  output logic        ap_abort,
  output logic        cdbgpwrupreq,
  input  logic        cdbgpwrupack,
  output logic        csyspwrupreq,
  input  logic        csyspwrupack
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;

  typedef enum logic {AP_IDLE = 1'b0, AP_BUSY = 1'b1} ap_state_t;

  typedef struct packed {
    logic          write;
    logic [BW-1:0] sel;
    logic [BW-1:0] addr;
    logic [DW-1:0] wdata;
  } ap_req_t;

  ap_state_t     state, state_nxt;
  logic          abort_nxt;
  ap_req_t       req_q;
  logic [DW-1:0] select_q, rdbuff_q;
  logic          orundetect_q, stickyorun_q, stickyerr_q, readok_q, wdataerr_q;
  logic          dbgreq_q, sysreq_q;
  logic [1:0]    dbg_sync_q, sys_sync_q;

  logic          dp_wr, abort_wr, dap_abort, ap_start, ap_done, ap_rd_ok;
  logic [3:0]    dpbanksel;
  logic [DW-1:0] ctrl_stat, dlpidr;

  assign dpbanksel = select_q[3:0];
  assign dp_wr     = bus_en && !bus_ap_ndp && !bus_r_nw;
  assign abort_wr  = dp_wr && (bus_addr == 2'd0);
  assign dap_abort = abort_wr && bus_wdata[0];
  assign ap_start  = bus_en && bus_ap_ndp && (state == AP_IDLE);
  assign ap_done   = (state == AP_BUSY) && ap_ready;
  assign ap_rd_ok  = ap_done && !req_q.write && !ap_err;

  // AP sequencer: completion takes precedence over a same-cycle DAPABORT
  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    case (state)
      AP_IDLE: if (ap_start) state_nxt = AP_BUSY;
      AP_BUSY: begin
        if (ap_done) begin
          state_nxt = AP_IDLE;
        end else if (dap_abort) begin
          state_nxt = AP_IDLE;
          abort_nxt = 1'b1;
        end
      end
      default: state_nxt = AP_IDLE;
    endcase
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AP_IDLE;
      ap_abort <= 1'b0;
    end else begin
      state    <= state_nxt;
      ap_abort <= abort_nxt;
    end
  end

  // Registers; sticky set inputs win over a same-cycle ABORT clear
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      select_q     <= '0;
      rdbuff_q     <= '0;
      orundetect_q <= 1'b0;
      stickyorun_q <= 1'b0;
      stickyerr_q  <= 1'b0;
      readok_q     <= 1'b0;
      wdataerr_q   <= 1'b0;
      dbgreq_q     <= 1'b0;
      sysreq_q     <= 1'b0;
      dbg_sync_q   <= '0;
      sys_sync_q   <= '0;
    end else begin
      if (ap_start) begin
        req_q.write <= !bus_r_nw;
        req_q.sel   <= select_q[31:24];
        req_q.addr  <= {select_q[7:4], bus_addr, 2'b00};
        req_q.wdata <= bus_wdata;
      end
      if (dp_wr && (bus_addr == 2'd2)) select_q <= bus_wdata;
      if (dp_wr && (bus_addr == 2'd1) && (dpbanksel == 4'd0)) begin
        orundetect_q <= bus_wdata[0];
        dbgreq_q     <= bus_wdata[28];
        sysreq_q     <= bus_wdata[30];
      end
      if (ap_rd_ok) rdbuff_q <= ap_rdata;
      if (ap_start && bus_r_nw) readok_q <= 1'b0;
      else if (ap_rd_ok)        readok_q <= 1'b1;
      stickyerr_q  <= (ap_done && ap_err) || (stickyerr_q && !(abort_wr && bus_wdata[2]));
      wdataerr_q   <= dp_set_wdataerr || (wdataerr_q && !(abort_wr && bus_wdata[3]));
      stickyorun_q <= dp_set_stickyorun || (stickyorun_q && !(abort_wr && bus_wdata[4]));
      dbg_sync_q   <= {dbg_sync_q[0], cdbgpwrupack};
      sys_sync_q   <= {sys_sync_q[0], csyspwrupack};
    end
  end

  assign ctrl_stat = {sys_sync_q[1], sysreq_q, dbg_sync_q[1], dbgreq_q, 20'd0,
                      wdataerr_q, readok_q, stickyerr_q, 1'b0, 2'b00,
                      stickyorun_q, orundetect_q};
  assign dlpidr    = {TINSTANCE, 24'd0, 4'h1};

  // Read decode; AP reads return the previous result held in RDBUFF
  always_comb begin
    bus_rdata = '0;
    if (bus_ap_ndp) begin
      bus_rdata = rdbuff_q;
    end else begin
      case (bus_addr)
        2'd0: bus_rdata = DPIDR;
        2'd1: begin
          case (dpbanksel)
            4'd0:    bus_rdata = ctrl_stat;
            4'd2:    bus_rdata = TARGETID;
            4'd3:    bus_rdata = dlpidr;
            default: bus_rdata = '0;
          endcase
        end
        default: bus_rdata = rdbuff_q;
      endcase
    end
  end

  assign dp_acc_fault        = bus_ap_ndp && (stickyerr_q || stickyorun_q || wdataerr_q);
  assign dp_acc_protocol_err = !bus_ap_ndp && (bus_addr == 2'd1) &&
                               ((dpbanksel > 4'd4) || (!bus_r_nw && (dpbanksel >= 4'd2)));

  assign ap_en         = (state == AP_BUSY);
  assign ap_rdy        = !ap_en;
  assign ap_write      = req_q.write;
  assign ap_sel        = req_q.sel;
  assign ap_addr       = req_q.addr;
  assign ap_wdata      = req_q.wdata;
  assign dp_orundetect = orundetect_q;
  assign cdbgpwrupreq  = dbgreq_q;
  assign csyspwrupreq  = sysreq_q;

endmodule

// File: tb/tb_opendap_sw_dp_regs.sv
// Bench for opendap_sw_dp_regs: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the DP.
module tb_opendap_sw_dp_regs;

  logic        swclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  bus_addr = '0;
  logic        bus_r_nw = 1'b0, bus_ap_ndp = 1'b0, bus_en = 1'b0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic        dp_set_wdataerr = 1'b0, dp_set_stickyorun = 1'b0;
  logic        dp_orundetect, dp_acc_fault, dp_acc_protocol_err;
  logic        ap_rdy, ap_en, ap_write, ap_abort;
  logic [7:0]  ap_sel, ap_addr;
  logic [31:0] ap_wdata, ap_rdata = '0;
  logic        ap_ready = 1'b0, ap_err = 1'b0;
  logic        cdbgpwrupreq, csyspwrupreq;
  logic        cdbgpwrupack = 1'b0, csyspwrupack = 1'b0;

  opendap_sw_dp_regs dut (
    .swclk(swclk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_r_nw(bus_r_nw), .bus_ap_ndp(bus_ap_ndp),
    .bus_wdata(bus_wdata), .bus_en(bus_en), .bus_rdata(bus_rdata),
    .dp_set_wdataerr(dp_set_wdataerr), .dp_set_stickyorun(dp_set_stickyorun),
    .dp_orundetect(dp_orundetect), .dp_acc_fault(dp_acc_fault),
    .dp_acc_protocol_err(dp_acc_protocol_err),
    .ap_rdy(ap_rdy), .ap_en(ap_en), .ap_write(ap_write), .ap_sel(ap_sel),
    .ap_addr(ap_addr), .ap_wdata(ap_wdata), .ap_rdata(ap_rdata),
    .ap_ready(ap_ready), .ap_err(ap_err), .ap_abort(ap_abort),
    .cdbgpwrupreq(cdbgpwrupreq), .cdbgpwrupack(cdbgpwrupack),
    .csyspwrupreq(csyspwrupreq), .csyspwrupack(csyspwrupack)
  );

  always #5 swclk = ~swclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- behavioural model of the DP ----------------
  bit          m_busy, m_abort, m_wr;
  logic [7:0]  m_sel, m_addr;
  logic [31:0] m_wdata, m_rdbuff, m_select;
  bit          m_readok, m_serr, m_sorun, m_wderr, m_orun, m_dbgreq, m_sysreq;
  bit          m_dbg_mid, m_dbg_ack, m_sys_mid, m_sys_ack;

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_wr = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
    m_rdbuff = '0; m_select = '0; m_readok = 0; m_serr = 0; m_sorun = 0; m_wderr = 0;
    m_orun = 0; m_dbgreq = 0; m_sysreq = 0;
    m_dbg_mid = 0; m_dbg_ack = 0; m_sys_mid = 0; m_sys_ack = 0;
  endtask

  task automatic model_step();
    bit wr_dp, abort_wr, complete, dapab, start;
    wr_dp    = bus_en && !bus_ap_ndp && !bus_r_nw;
    abort_wr = wr_dp && (bus_addr == 2'd0);
    complete = m_busy && ap_ready;
    dapab    = abort_wr && bus_wdata[0] && m_busy && !complete;
    start    = bus_en && bus_ap_ndp && !m_busy;
    m_serr   = (complete && ap_err) || (m_serr && !(abort_wr && bus_wdata[2]));
    m_wderr  = dp_set_wdataerr || (m_wderr && !(abort_wr && bus_wdata[3]));
    m_sorun  = dp_set_stickyorun || (m_sorun && !(abort_wr && bus_wdata[4]));
    if (complete && !m_wr && !ap_err) begin
      m_rdbuff = ap_rdata;
      m_readok = 1;
    end
    if (start && bus_r_nw) m_readok = 0;
    m_abort = dapab;
    if (complete || dapab) m_busy = 0;
    else if (start) begin
      m_busy = 1; m_wr = !bus_r_nw; m_sel = m_select[31:24];
      m_addr = {m_select[7:4], bus_addr, 2'b00}; m_wdata = bus_wdata;
    end
    if (wr_dp && bus_addr == 2'd1 && m_select[3:0] == 4'd0) begin
      m_orun = bus_wdata[0]; m_dbgreq = bus_wdata[28]; m_sysreq = bus_wdata[30];
    end
    if (wr_dp && bus_addr == 2'd2) m_select = bus_wdata;
    m_dbg_ack = m_dbg_mid; m_dbg_mid = cdbgpwrupack;
    m_sys_ack = m_sys_mid; m_sys_mid = csyspwrupack;
  endtask

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] c;
    c = 32'd0;
    if (m_orun)    c = c + 32'h0000_0001;
    if (m_sorun)   c = c + 32'h0000_0002;
    if (m_serr)    c = c + 32'h0000_0020;
    if (m_readok)  c = c + 32'h0000_0040;
    if (m_wderr)   c = c + 32'h0000_0080;
    if (m_dbgreq)  c = c + 32'h1000_0000;
    if (m_dbg_ack) c = c + 32'h2000_0000;
    if (m_sysreq)  c = c + 32'h4000_0000;
    if (m_sys_ack) c = c + 32'h8000_0000;
    return c;
  endfunction

  function automatic logic [31:0] exp_read(input logic ndp, input logic [1:0] a);
    if (ndp) return m_rdbuff;
    if (a == 2'd0) return 32'h2ba01477;
    if (a != 2'd1) return m_rdbuff;
    case (m_select[3:0])
      4'd0:    return exp_ctrl();
      4'd2:    return 32'h0000_0001;
      4'd3:    return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit exp_prot(input logic ndp, input logic rnw, input logic [1:0] a);
    int bank;
    bank = int'(m_select[3:0]);
    return !ndp && a == 2'd1 && (bank > 4 || (!rnw && bank >= 2));
  endfunction

  always @(posedge swclk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison against the model
  always @(negedge swclk) begin
    if (!rst_n) begin
      check1("reset_ap_en", ap_en, 1'b0);
      check1("reset_ap_rdy", ap_rdy, 1'b1);
      check1("reset_ap_abort", ap_abort, 1'b0);
    end else begin
      check1("ap_en", ap_en, m_busy);
      check1("ap_rdy", ap_rdy, !m_busy);
      check1("ap_abort", ap_abort, m_abort);
      if (m_busy) begin
        check1("ap_write", ap_write, m_wr);
        check("ap_sel", 32'(ap_sel), 32'(m_sel));
        check("ap_addr", 32'(ap_addr), 32'(m_addr));
        check("ap_wdata", ap_wdata, m_wdata);
      end
      check1("orundetect", dp_orundetect, m_orun);
      check1("cdbgpwrupreq", cdbgpwrupreq, m_dbgreq);
      check1("csyspwrupreq", csyspwrupreq, m_sysreq);
      check1("fault", dp_acc_fault, bus_ap_ndp && (m_serr || m_sorun || m_wderr));
      check1("protocol_err", dp_acc_protocol_err, exp_prot(bus_ap_ndp, bus_r_nw, bus_addr));
      if (bus_en && bus_r_nw) check("bus_rdata", bus_rdata, exp_read(bus_ap_ndp, bus_addr));
      if (bus_en && bus_ap_ndp) check1("ap_single_outstanding", ap_en, 1'b0);
    end
  end

  // ---------------- AP slave responder ----------------
  int          cfg_lat = -1;
  bit          hold_ready = 0, use_cfg_data = 0, cfg_err = 0;
  logic [31:0] cfg_rdata = '0;
  int          err_rate = 0;

  initial begin
    int  lat;
    bit  active;
    lat = 0; active = 0;
    forever begin
      @(posedge swclk); #1;
      if (!ap_en) begin
        active = 0; ap_ready = 1'b0; ap_err = 1'b0;
      end else begin
        if (!active) begin
          active = 1;
          lat = (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(0, 4));
        end
        if (hold_ready) ap_ready = 1'b0;
        else if (lat == 0) begin
          ap_ready = 1'b1;
          ap_rdata = use_cfg_data ? cfg_rdata : $urandom;
          ap_err   = (err_rate > 0) ? (int'($urandom_range(0, 99)) < err_rate) : cfg_err;
        end else begin
          lat--; ap_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge swclk); #2;
  endtask

  task automatic set_hdr(input logic ndp, input logic rnw, input logic [1:0] a, input logic [31:0] wd);
    bus_ap_ndp = ndp; bus_r_nw = rnw; bus_addr = a; bus_wdata = wd;
  endtask

  task automatic op(input logic ndp, input logic rnw, input logic [1:0] a,
                    input logic [31:0] wd, output logic [31:0] rd);
    set_hdr(ndp, rnw, a, wd);
    bus_en = 1'b1;
    @(negedge swclk);
    rd = bus_rdata;
    tick();
    bus_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!ap_en) break;
      tick();
    end
    check1("ap_idle_timeout", ap_en, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check1("lit_reset_ap_rdy", ap_rdy, 1'b1);
    check1("lit_reset_ap_en", ap_en, 1'b0);
    rst_n = 1'b1;
    tick();

    // DPIDR
    set_hdr(1'b0, 1'b1, 2'd0, 32'd0); bus_en = 1'b1;
    @(negedge swclk);
    check("lit_dpidr", bus_rdata, 32'h2ba01477);
    check1("lit_dpidr_fault", dp_acc_fault, 1'b0);
    check1("lit_dpidr_prot", dp_acc_protocol_err, 1'b0);
    tick(); bus_en = 1'b0;

    // SELECT then posted AP read
    op(1'b0, 1'b0, 2'd2, 32'h05000013, rd);
    cfg_lat = 3; use_cfg_data = 1; cfg_rdata = 32'hcafef00d; cfg_err = 0;
    op(1'b1, 1'b1, 2'd2, 32'd0, rd);
    check("lit_posted_first", rd, 32'h0);
    check("lit_ap_sel", 32'(ap_sel), 32'h05);
    check("lit_ap_addr", 32'(ap_addr), 32'h18);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge swclk);
      if (ap_rdy) break;
      n++;
    end
    check("lit_ap_rdy_low_cycles", n, 4);
    tick();
    op(1'b0, 1'b1, 2'd3, 32'd0, rd);
    check("lit_rdbuff", rd, 32'hcafef00d);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_dlpidr", rd, 32'h00000001);
    op(1'b0, 1'b0, 2'd2, 32'h05000010, rd);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_ctrl_readok", rd, 32'h00000040);

    // AP write completing with error
    cfg_lat = 1; cfg_err = 1;
    op(1'b1, 1'b0, 2'd1, 32'h12345678, rd);
    wait_idle();
    cfg_err = 0;
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_ctrl_stickyerr", rd, 32'h00000060);
    set_hdr(1'b1, 1'b1, 2'd0, 32'd0);
    @(negedge swclk);
    check1("lit_fault_set", dp_acc_fault, 1'b1);
    tick();
    op(1'b0, 1'b0, 2'd0, 32'h4, rd);
    set_hdr(1'b1, 1'b1, 2'd0, 32'd0);
    @(negedge swclk);
    check1("lit_fault_cleared", dp_acc_fault, 1'b0);
    tick();

    // set beats clear
    set_hdr(1'b0, 1'b0, 2'd0, 32'h8); bus_en = 1'b1; dp_set_wdataerr = 1'b1;
    tick();
    bus_en = 1'b0; dp_set_wdataerr = 1'b0;
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_wdataerr_kept", rd, 32'h000000c0);
    op(1'b0, 1'b0, 2'd0, 32'h8, rd);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_wdataerr_cleared", rd, 32'h00000040);

    // DAPABORT of a stalled read
    hold_ready = 1;
    op(1'b1, 1'b1, 2'd0, 32'd0, rd);
    check("lit_posted_second", rd, 32'hcafef00d);
    tick(); tick();
    @(negedge swclk);
    check1("lit_stalled_ap_en", ap_en, 1'b1);
    tick();
    set_hdr(1'b0, 1'b0, 2'd0, 32'h1); bus_en = 1'b1;
    tick();
    bus_en = 1'b0;
    @(negedge swclk);
    check1("lit_abort_pulse", ap_abort, 1'b1);
    check1("lit_abort_ap_en", ap_en, 1'b0);
    check1("lit_abort_ap_rdy", ap_rdy, 1'b1);
    tick();
    @(negedge swclk);
    check1("lit_abort_pulse_end", ap_abort, 1'b0);
    tick();
    hold_ready = 0;
    op(1'b0, 1'b1, 2'd3, 32'd0, rd);
    check("lit_rdbuff_after_abort", rd, 32'hcafef00d);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_ctrl_after_abort", rd, 32'h00000000);

    // bank decode and protocol errors
    op(1'b0, 1'b0, 2'd2, 32'h5, rd);
    set_hdr(1'b0, 1'b1, 2'd1, 32'd0); bus_en = 1'b1;
    @(negedge swclk);
    check1("lit_prot_bank5", dp_acc_protocol_err, 1'b1);
    tick(); bus_en = 1'b0;
    op(1'b0, 1'b0, 2'd2, 32'h2, rd);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_targetid", rd, 32'h00000001);
    set_hdr(1'b0, 1'b0, 2'd1, 32'd0);
    @(negedge swclk);
    check1("lit_prot_write_bank2", dp_acc_protocol_err, 1'b1);
    tick();

    // power-up handshake
    op(1'b0, 1'b0, 2'd2, 32'h0, rd);
    set_hdr(1'b0, 1'b0, 2'd1, 32'h50000000); bus_en = 1'b1;
    cdbgpwrupack = 1'b1; csyspwrupack = 1'b1;
    tick(); bus_en = 1'b0;
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_pwr_cycle2", rd, 32'h50000000);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_pwr_cycle3", rd, 32'hf0000000);
    op(1'b0, 1'b1, 2'd1, 32'd0, rd);
    check("lit_pwr_cycle4", rd, 32'hf0000000);
    check1("lit_dbgreq_out", cdbgpwrupreq, 1'b1);

    // randomized traffic
    cfg_lat = -1; use_cfg_data = 0; err_rate = 15;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] bank;
      logic [1:0] a;
      r = int'($urandom_range(0, 99));
      a = 2'($urandom_range(0, 3));
      dp_set_wdataerr   = ($urandom_range(0, 59) == 0);
      dp_set_stickyorun = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) cdbgpwrupack = ~cdbgpwrupack;
      if ($urandom_range(0, 19) == 0) csyspwrupack = ~csyspwrupack;
      bus_en = 1'b0;
      if (r < 25) begin
        set_hdr(1'($urandom), 1'($urandom), a, $urandom);
      end else if (r < 50) begin
        set_hdr(1'b0, 1'b1, a, 32'd0); bus_en = 1'b1;
      end else if (r < 75) begin
        bank = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
        if (a == 2'd0)      set_hdr(1'b0, 1'b0, a, 32'($urandom_range(0, 31)));
        else if (a == 2'd2) set_hdr(1'b0, 1'b0, a, {8'($urandom), 16'($urandom), 4'($urandom), bank});
        else                set_hdr(1'b0, 1'b0, a, $urandom);
        bus_en = 1'b1;
      end else begin
        set_hdr(1'b1, 1'($urandom), a, $urandom);
        bus_en = (!m_busy && !(m_serr || m_sorun || m_wderr)) ? 1'b1 : 1'b0;
      end
      tick();
    end
    bus_en = 1'b0; dp_set_wdataerr = 1'b0; dp_set_stickyorun = 1'b0; err_rate = 0;

    // reset during an outstanding transfer
    op(1'b0, 1'b0, 2'd0, 32'h1c, rd);
    wait_idle();
    hold_ready = 1;
    op(1'b1, 1'b1, 2'd0, 32'd0, rd);
    #1 rst_n = 1'b0;
    #1;
    check1("lit_rst_mid_ap_en", ap_en, 1'b0);
    check1("lit_rst_mid_ap_abort", ap_abort, 1'b0);
    check1("lit_rst_mid_ap_rdy", ap_rdy, 1'b1);
    tick(); tick();
    rst_n = 1'b1; hold_ready = 0;
    tick();
    op(1'b0, 1'b1, 2'd3, 32'd0, rd);
    check("lit_rdbuff_after_reset", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
